mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_pkg.sv | 20 ++
 rtl/mem_burst_ctr.sv | 52 +++++
 rtl/mem_access_unit.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_pkg
// Shared definitions for the memory access unit:
//   ADDR_W_DEF / DATA_W_DEF : default address and data widths
//   LEN_W                   : width of the burst length field (length minus 1)
//   state_t                 : FSM state encoding (IDLE, ACCESS, DONE)
// -----------------------------------------------------------------------------
package mem_access_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int LEN_W      = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/mem_burst_ctr.sv
// -----------------------------------------------------------------------------
// mem_burst_ctr
// Beat counter and address generator for burst reads. Loads a start address
// and a remaining-beat count, then advances the address by one (wrapping at
// 2^ADDR_W) for every ACCESS cycle that is not the final beat.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   load           : capture load_addr/load_len (request accepted)
//   load_addr      : burst start address
//   load_len       : beats minus 1 (0 for writes)
//   step           : an ACCESS beat is in progress
//   addr           : current beat address, drives the memory address
//   last           : current beat is the final one
// -----------------------------------------------------------------------------
module mem_burst_ctr
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [LEN_W-1:0]  load_len,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [LEN_W-1:0] remain;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the reset branch sits in the sensitivity list so it acts
  // without a clock edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr   <= '0;
      remain <= '0;
    end else if (load) begin
      addr   <= load_addr;
      remain <= load_len;
    end else if (step && (remain != '0)) begin
      // Natural overflow gives the wrap from 2^ADDR_W-1 to 0. The address is
      // not advanced after the final beat so it holds through DONE and IDLE.
      addr   <= addr + ADDR_W'(1);
      remain <= remain - LEN_W'(1);
    end
  end

  assign last = (remain == '0);

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Turns a valid/ready request into memory access cycles on a simple SRAM-style
// port (A/WD/WE out, combinational RD in) and returns a one-cycle response
// strobe per beat. FSM: IDLE -> ACCESS (one cycle per beat) -> DONE -> IDLE.
//
// Configuration macro: MEM_ACCESS_BURST_EN
//   defined   : req_len port present; reads run req_len+1 beats at
//               consecutive (wrapping) addresses; writes are single beat.
//   undefined : no req_len port, no burst counter; every request is one beat.
//
// Ports:
//   clock, reset_n      : clock and asynchronous active-low reset
//   req_valid/req_ready : request handshake (ready only in IDLE)
//   req_we              : 1 = write, 0 = read
//   req_addr, req_wdata : start address and write data
//   req_len             : burst length minus 1 (burst build only)
//   rsp_valid           : one-cycle strobe per beat (no backpressure)
//   rsp_rdata           : read data, holds its value across writes
//   rsp_last            : final beat of the request
//   busy                : request in progress
//   A, WD, WE           : memory address, write data, write enable
//   RD                  : memory read data, combinational from A
// -----------------------------------------------------------------------------
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
`ifdef MEM_ACCESS_BURST_EN
  input  logic [LEN_W-1:0]  req_len,
`endif
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_last,
  output logic              busy,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] WD,
  output logic              WE,
  input  logic [DATA_W-1:0] RD
);

  state_t            state;
  state_t            state_nxt;
  logic              accept;
  logic              in_access;
  logic              last_beat;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;

  assign accept    = (state == ST_IDLE) && req_valid;
  assign in_access = (state == ST_ACCESS);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // NOTE: next state gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (req_valid) state_nxt = ST_ACCESS;
      ST_ACCESS: if (last_beat) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request capture. req_valid outside IDLE never reaches here, so a request
  // presented while busy is simply not seen until the unit returns to IDLE.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      wdata_q <= req_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Address generation / beat counting
  // ---------------------------------------------------------------------------
`ifdef MEM_ACCESS_BURST_EN
  logic [LEN_W-1:0] load_len;

  // Writes always run a single beat regardless of req_len.
  assign load_len = req_we ? '0 : req_len;

  mem_burst_ctr #(
    .ADDR_W (ADDR_W)
  ) u_burst_ctr (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (accept),
    .load_addr (req_addr),
    .load_len  (load_len),
    .step      (in_access),
    .addr      (A),
    .last      (last_beat)
  );
`else
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    A <= '0;
    else if (accept) A <= req_addr;
  end

  assign last_beat = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Response path: each ACCESS beat produces a strobe in the following cycle,
  // so a burst's strobes are back-to-back and the final one lands in DONE.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= in_access;
      rsp_last  <= in_access && last_beat;
      if (in_access && !we_q) rsp_rdata <= RD;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. WE is decoded from the state so an asynchronous reset removes it
  // immediately and it can only be high in ACCESS.
  // ---------------------------------------------------------------------------
  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign WE        = in_access && we_q;
  assign WD        = wdata_q;

endmodule
